// File: rtl/simple_pkg.sv
// Shared definitions for the simple control unit and datapath.
// Covers the instruction field layout, the FSM states, the instruction types and the ALU opcodes.
package simple_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 13;
    localparam int ADDR_MSB = 12;
    localparam int ADDR_LSB = 11;
    localparam int TYPE_MSB = 10;
    localparam int TYPE_LSB = 9;
    localparam int FLAG_BIT = 8;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} ctrl_state_t;

    typedef enum logic [1:0] {T_SYS = 2'b00, T_LOADA, T_ALU, T_STORE} instr_type_t;

    // Encoding labels shared with the datapath ALU.
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_PASS, ALU_SHL
    } alu_op_t;

    // Bits [7:0] are reserved, so only the upper byte of an instruction is decoded.
    function automatic instr_type_t instr_type(input logic [INSTR_W-1:FLAG_BIT] ir);
        return instr_type_t'(ir[TYPE_MSB:TYPE_LSB]);
    endfunction

endpackage

// File: rtl/simple_pc.sv
// Program counter for the simple control unit.
// It clears on reset, advances by one when inc is high, and wraps modulo 2^PC_W.
module simple_pc #(
    parameter int PC_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= '0;
        else if (inc)
            pc <= pc + PC_W'(1);
    end

endmodule

// File: rtl/simple_ctrl_fsm.sv
// Fetch/decode control unit: FETCH -> DECODE -> EXEC [-> WB], and HALT until reset.
// Every output is registered, so the datapath enables are glitch-free single-cycle pulses.
module simple_ctrl_fsm
    import simple_pkg::*;
#(
    parameter int PC_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    output logic               fetch_req,
    output logic [PC_W-1:0]    pc,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instruction_wire,
    output logic               A_ce,
    output logic               ALU_ce,
    output logic               RF_we,
    output logic [2:0]         ALU_opcode_wire,
    output logic [1:0]         RF_addr,
    output logic               halted
);

    ctrl_state_t                 state;
    logic [INSTR_W-1:FLAG_BIT]   ir;
    logic                        pc_inc;
    logic                        unused_reserved;

    assign unused_reserved = ^instruction_wire[FLAG_BIT-1:0];
    assign pc_inc          = (state == FETCH) && instr_valid;

    simple_pc #(.PC_W(PC_W)) u_pc (
        .clk (clk),
        .rst (rst),
        .inc (pc_inc),
        .pc  (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= FETCH;
            ir              <= '0;
            fetch_req       <= 1'b1;
            A_ce            <= 1'b0;
            ALU_ce          <= 1'b0;
            RF_we           <= 1'b0;
            ALU_opcode_wire <= '0;
            RF_addr         <= '0;
            halted          <= 1'b0;
        end else begin
            // Enables are set on the edge that enters their cycle, so each one lasts exactly one cycle.
            A_ce   <= 1'b0;
            ALU_ce <= 1'b0;
            RF_we  <= 1'b0;

            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir        <= instruction_wire[INSTR_W-1:FLAG_BIT];
                        fetch_req <= 1'b0;
                        state     <= DECODE;
                    end
                end

                DECODE: begin
                    ALU_opcode_wire <= ir[OPC_MSB:OPC_LSB];
                    RF_addr         <= ir[ADDR_MSB:ADDR_LSB];
                    case (instr_type(ir))
                        T_SYS: begin
                            if (ir[FLAG_BIT]) begin
                                halted <= 1'b1;
                                state  <= HALT;
                            end else begin
                                fetch_req <= 1'b1;
                                state     <= FETCH;
                            end
                        end
                        T_LOADA: begin
                            A_ce  <= 1'b1;
                            state <= EXEC;
                        end
                        T_ALU: begin
                            ALU_ce <= 1'b1;
                            state  <= EXEC;
                        end
                        T_STORE: begin
                            RF_we <= 1'b1;
                            state <= EXEC;
                        end
                    endcase
                end

                EXEC: begin
                    if (instr_type(ir) == T_ALU) begin
                        RF_we <= ir[FLAG_BIT];
                        state <= WB;
                    end else begin
                        fetch_req <= 1'b1;
                        state     <= FETCH;
                    end
                end

                WB: begin
                    fetch_req <= 1'b1;
                    state     <= FETCH;
                end

                HALT: state <= HALT;

                default: begin
                    fetch_req <= 1'b1;
                    state     <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_ctrl_fsm.sv
// Randomized scoreboard bench for simple_ctrl_fsm.
// The driver predicts each instruction's enable pulses and cycle cost, and a negedge monitor matches them.
module tb_simple_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [4:0]  pc;
    logic        instr_valid;
    logic [15:0] instruction_wire;
    logic        A_ce, ALU_ce, RF_we;
    logic [2:0]  ALU_opcode_wire;
    logic [1:0]  RF_addr;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [2:0] en;    // {A_ce, ALU_ce, RF_we}
        logic [2:0] opc;
        logic [1:0] addr;
    } ev_t;

    ev_t        sb[$];
    logic [4:0] m_pc;

    simple_ctrl_fsm #(.PC_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_req        (fetch_req),
        .pc               (pc),
        .instr_valid      (instr_valid),
        .instruction_wire (instruction_wire),
        .A_ce             (A_ce),
        .ALU_ce           (ALU_ce),
        .RF_we            (RF_we),
        .ALU_opcode_wire  (ALU_opcode_wire),
        .RF_addr          (RF_addr),
        .halted           (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any enable pulse, or an expected pulse that has come due, pops one scoreboard entry.
    always @(negedge clk) begin
        logic [2:0] en;
        ev_t        e;
        en = {A_ce, ALU_ce, RF_we};
        if (en != 3'b000 || (sb.size() != 0 && sb[0].cyc <= cyc)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(en), 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_enables", 32'(en), 32'(e.en));
                check("pulse_alu_op", 32'(ALU_opcode_wire), 32'(e.opc));
                check("pulse_rf_addr", 32'(RF_addr), 32'(e.addr));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        m_pc = '0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_enables", 32'({A_ce, ALU_ce, RF_we}), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fetch_req", 32'(fetch_req), 32'd1);
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the negedge where the next FETCH begins.
    task automatic issue(input logic [15:0] ins, input int waits);
        logic [1:0] ty;
        int         acc;
        int         cpi;
        bit         is_halt;
        ty      = ins[10:9];
        is_halt = (ty == 2'b00) && ins[8];
        for (int i = 0; i < waits; i++) begin
            instr_valid      = 1'b0;
            instruction_wire = 16'($urandom);
            check("wait_fetch_req", 32'(fetch_req), 32'd1);
            check("wait_pc", 32'(pc), 32'(m_pc));
            @(negedge clk);
        end
        check("fetch_req", 32'(fetch_req), 32'd1);
        check("fetch_pc", 32'(pc), 32'(m_pc));
        instr_valid      = 1'b1;
        instruction_wire = ins;
        acc = cyc + 1;
        case (ty)
            2'b01: begin
                sb.push_back('{acc + 1, 3'b100, ins[15:13], ins[12:11]});
                cpi = 3;
            end
            2'b11: begin
                sb.push_back('{acc + 1, 3'b001, ins[15:13], ins[12:11]});
                cpi = 3;
            end
            2'b10: begin
                sb.push_back('{acc + 1, 3'b010, ins[15:13], ins[12:11]});
                if (ins[8]) sb.push_back('{acc + 2, 3'b001, ins[15:13], ins[12:11]});
                cpi = 4;
            end
            default: cpi = 2;
        endcase
        m_pc = m_pc + 5'd1;
        @(negedge clk);
        if (is_halt) begin
            for (int i = 0; i < 4; i++) begin
                instr_valid      = 1'b1;
                instruction_wire = 16'($urandom);
                @(negedge clk);
                check("halted", 32'(halted), 32'd1);
                check("halt_fetch_req", 32'(fetch_req), 32'd0);
                check("halt_pc", 32'(pc), 32'(m_pc));
            end
            instr_valid = 1'b0;
        end else begin
            while (cyc < acc + cpi - 1) begin
                check("busy_fetch_req", 32'(fetch_req), 32'd0);
                instr_valid      = 1'($urandom_range(0, 1));
                instruction_wire = 16'($urandom);
                @(negedge clk);
            end
            instr_valid = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ins;
        int          acc;
        rst = 1'b1;
        instr_valid = 1'b0;
        instruction_wire = '0;
        m_pc = '0;
        do_reset();
        @(negedge clk);
        check("post_rst_fetch_req", 32'(fetch_req), 32'd1);
        check("post_rst_pc", 32'(pc), 32'd0);

        issue(16'h1200, 0);   // LOADA, RF_addr 2
        issue(16'h6D00, 0);   // ALU op 3, RF_addr 1, write-back
        issue(16'h6C00, 0);   // same without write-back
        issue(16'h0000, 5);   // NOP after five wait cycles

        for (int i = 0; i < 60; i++) begin
            ins = 16'($urandom);
            if (ins[10:9] == 2'b00) ins[8] = 1'b0;
            issue(ins, int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 32; i++) issue(16'h0000, 0);
        issue(16'h0100, 0);   // halt
        do_reset();

        // Reset during the EXEC cycle of an ALU write-back instruction.
        @(negedge clk);
        check("mid_fetch_req", 32'(fetch_req), 32'd1);
        instr_valid      = 1'b1;
        instruction_wire = 16'h6D00;
        acc = cyc + 1;
        sb.push_back('{acc + 1, 3'b010, 3'd3, 2'd1});
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("mid_exec_alu_ce", 32'(ALU_ce), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        m_pc = '0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_enables", 32'({A_ce, ALU_ce, RF_we}), 32'd0);
        check("mid_rst_fetch_req", 32'(fetch_req), 32'd1);
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        check("mid_rst_no_wb", 32'(RF_we), 32'd0);
        issue(16'h1200, 0);
        repeat (2) @(negedge clk);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
